trap_seq: RTL

- Trap/return sequencer on the write side of the machine-mode CSR register file.
- Reads the CSR array, accepts synchronous exceptions, qualified external interrupts and MRET from the core.
- Performs the CSR updates one per cycle through the single CSR write port (wreq/windex/wdata).
- Issues one PC-redirect pulse to the fetch stage after the updates.

---
 rtl/trap_seq_pkg.sv | 35 +++
 rtl/trap_seq_target.sv | 32 +++
 rtl/trap_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/trap_seq_pkg.sv
// Shared definitions for the machine-mode trap/return sequencer.
// CSR slot indices, mstatus/mip bit positions and sequencer states.
package trap_seq_pkg;

  localparam logic [3:0] CSR_IDX_MSTATUS = 4'd0;
  localparam logic [3:0] CSR_IDX_MTVEC   = 4'd1;
  localparam logic [3:0] CSR_IDX_MEPC    = 4'd2;
  localparam logic [3:0] CSR_IDX_MCAUSE  = 4'd3;
  localparam logic [3:0] CSR_IDX_MTVAL   = 4'd4;
  localparam logic [3:0] CSR_IDX_MIP     = 4'd5;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIP_MEIP       = 11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
  localparam logic [1:0] PRIV_M              = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_TVAL,
    ST_W_STAT,
    ST_M_STAT,
    ST_REDIR
  } trap_state_t;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/trap_seq_target.sv
// Redirect target for trap entry (direct or vectored mtvec) and MRET (mepc).
module trap_target_calc
  import trap_seq_pkg::*;
#(
  parameter bit VEC_EN = 1'b1
) (
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_cause,
  input  logic        i_is_mret,
  output logic [31:0] o_target
);

  logic [31:0] w_base;
  logic [31:0] w_offset;
  logic        w_vectored;

  // Only interrupts are vectored; exceptions always land on the base.
  assign w_base     = align4(i_mtvec);
  assign w_vectored = VEC_EN && (i_mtvec[1:0] == MTVEC_MODE_VECTORED) && i_cause[31];
  assign w_offset   = {1'b0, i_cause[30:0]} << 2;

  always_comb begin
    o_target = w_base;
    if (i_is_mret) begin
      o_target = align4(i_mepc);
    end else if (w_vectored) begin
      o_target = w_base + w_offset;
    end
  end

endmodule

// File: rtl/trap_seq.sv
// Trap/return sequencer: accepts exception, interrupt or MRET, then walks the
// CSR updates through the single write port and finishes with one PC redirect.
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter bit VEC_EN       = 1'b1,
  parameter int EXT_IRQ_CODE = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] csr [0:15],
  input  logic        exc_req,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_tval,
  output logic        exc_ack,
  input  logic        irq_window,
  output logic        irq_ack,
  input  logic [31:0] irq_epc,
  input  logic        mret_req,
  output logic        mret_ack,
  output logic        wreq,
  output logic [3:0]  windex,
  output logic [31:0] wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  trap_state_t r_state;
  trap_state_t w_next;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic        r_is_mret;

  logic        w_idle;
  logic        w_irq_pend;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_mret;
  logic [31:0] w_mstatus;
  logic [31:0] w_trap_stat;
  logic [31:0] w_mret_stat;
  logic [31:0] w_target;

  assign w_mstatus  = csr[CSR_IDX_MSTATUS];
  assign w_irq_pend = csr[CSR_IDX_MIP][MIP_MEIP] & w_mstatus[MSTATUS_MIE] & irq_window;

  // Acks are combinational; gating with rstn keeps them low while in reset.
  assign w_idle      = rstn && (r_state == ST_IDLE);
  assign w_take_exc  = w_idle & exc_req;
  assign w_take_irq  = w_idle & ~exc_req & w_irq_pend;
  assign w_take_mret = w_idle & ~exc_req & ~w_irq_pend & mret_req;

  assign exc_ack  = w_take_exc;
  assign irq_ack  = w_take_irq;
  assign mret_ack = w_take_mret;
  assign busy     = (r_state != ST_IDLE);

  always_comb begin
    w_trap_stat                                = w_mstatus;
    w_trap_stat[MSTATUS_MPIE]                  = w_mstatus[MSTATUS_MIE];
    w_trap_stat[MSTATUS_MIE]                   = 1'b0;
    w_trap_stat[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;

    w_mret_stat                                = w_mstatus;
    w_mret_stat[MSTATUS_MIE]                   = w_mstatus[MSTATUS_MPIE];
    w_mret_stat[MSTATUS_MPIE]                  = 1'b1;
    w_mret_stat[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
  end

  trap_target_calc #(
    .VEC_EN(VEC_EN)
  ) u_target (
    .i_mtvec  (csr[CSR_IDX_MTVEC]),
    .i_mepc   (csr[CSR_IDX_MEPC]),
    .i_cause  (r_cause),
    .i_is_mret(r_is_mret),
    .o_target (w_target)
  );

  always_comb begin
    w_next         = r_state;
    wreq           = 1'b0;
    windex         = 4'd0;
    wdata          = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_exc || w_take_irq) begin
          w_next = ST_W_EPC;
        end else if (w_take_mret) begin
          w_next = ST_M_STAT;
        end
      end
      ST_W_EPC: begin
        wreq   = 1'b1;
        windex = CSR_IDX_MEPC;
        wdata  = align4(r_epc);
        w_next = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        wreq   = 1'b1;
        windex = CSR_IDX_MCAUSE;
        wdata  = r_cause;
        w_next = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        wreq   = 1'b1;
        windex = CSR_IDX_MTVAL;
        wdata  = r_tval;
        w_next = ST_W_STAT;
      end
      ST_W_STAT: begin
        wreq   = 1'b1;
        windex = CSR_IDX_MSTATUS;
        wdata  = w_trap_stat;
        w_next = ST_REDIR;
      end
      ST_M_STAT: begin
        wreq   = 1'b1;
        windex = CSR_IDX_MSTATUS;
        wdata  = w_mret_stat;
        w_next = ST_REDIR;
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = w_target;
        w_next         = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_epc     <= 32'd0;
      r_cause   <= 32'd0;
      r_tval    <= 32'd0;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take_exc) begin
        r_epc     <= exc_epc;
        r_cause   <= {1'b0, exc_cause};
        r_tval    <= exc_tval;
        r_is_mret <= 1'b0;
      end else if (w_take_irq) begin
        r_epc     <= irq_epc;
        r_cause   <= {1'b1, 31'(EXT_IRQ_CODE)};
        r_tval    <= 32'd0;
        r_is_mret <= 1'b0;
      end else if (w_take_mret) begin
        r_is_mret <= 1'b1;
      end
    end
  end

endmodule
